// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline register.
package pipe_pkg;

    // Encoding doubles as the entry count held by the block.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } pipe_state_t;

    localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous clear.
module pipe_data_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset and clear both force zero; a clear beats a same-cycle load.
    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (ld)    q <= d;
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register: full throughput with fully registered
// in_ready/out_valid. Optional stall statistics enabled by PIPE_SKID_STATS_EN.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    pipe_state_t      state, state_n;
    logic             in_fire, out_fire;
    logic             main_ld, skid_ld, main_from_skid;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    // Handshake flags come only from registered state.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_q;
    assign main_d    = main_from_skid ? skid_q : in_data;

    // State register; flush empties the block regardless of handshakes.
    always_ff @(posedge clk) begin
        if (rst)        state <= EMPTY;
        else if (flush) state <= EMPTY;
        else            state <= state_n;
    end

    // Next state and register load enables.
    always_comb begin
        state_n        = state;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_ld = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    skid_ld = 1'b1;
                    state_n = FULL;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_n        = BUSY;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // Occupancy decode from state.
    always_comb begin
        case (state)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    pipe_data_reg #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .ld  (skid_ld),
        .d   (in_data),
        .q   (skid_q)
    );

`ifdef PIPE_SKID_STATS_EN
    // Saturating count of cycles the downstream holds off a valid entry;
    // survives flush so stall history is kept across pipeline clears.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter CNT_W, default 16: stall-counter width (used only with PIPE_SKID_STATS_EN).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous clear of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry offered.
REQ-007 SHALL have port in_ready  output  1  block accepts an entry this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream entry offered.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-012 SHALL have port occupancy  output  2  entries held, 0..2.
REQ-013 SHALL have port stall_cnt  output  CNT_W  output-stall cycles; present only with PIPE_SKID_STATS_EN.

Function
REQ-014 Handshakes: in-fire = in_valid & in_ready; out-fire = out_valid & out_ready; payload moves only on fire.
REQ-015 States: EMPTY (0 entries), BUSY (main reg full), FULL (main and skid regs full); occupancy = 0/1/2 respectively.
REQ-016 out_valid = (state != EMPTY); in_ready = (state != FULL); both decoded from registered state only, no combinational in-to-out path.
REQ-017 out_data is the main register; latency in_data->out_data is exactly 1 cycle; sustained throughput 1 entry/cycle with out_ready held high.
REQ-018 EMPTY: in-fire -> main<=in_data, BUSY; else stay.
REQ-019 BUSY: in-fire & out-fire -> main<=in_data, stay BUSY; in-fire only -> skid<=in_data, FULL; out-fire only -> EMPTY; neither -> hold.
REQ-020 FULL: out-fire -> main<=skid, BUSY; else hold; in_data ignored (in_ready=0).
REQ-021 Order preserved: entries leave in arrival order; no entry duplicated or dropped except by flush/rst.
REQ-022 flush=1: next state EMPTY, main and skid cleared to 0, any in-fire that cycle discarded, any out-fire that cycle still counts as consumed by downstream.
REQ-023 Priority: rst > flush > handshake updates.
REQ-024 While EMPTY, out_data retains last main value (0 after rst/flush); stable whenever out_valid & !out_ready.

Reset
REQ-025 rst=1 at a clock edge: state EMPTY, main=0, skid=0, occupancy=0, out_valid=0, in_ready=1, stall_cnt=0; applies mid-transfer, discarding all entries.

Configuration
REQ-026 Macro PIPE_SKID_STATS_EN: when defined, stall_cnt exists and increments each cycle with out_valid & !out_ready, saturating at all-ones, cleared by rst only (not by flush).
REQ-027 When PIPE_SKID_STATS_EN is undefined, stall_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-028 Shared package pipe_pkg SHALL hold the state typedef (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) and occupancy width constant.
REQ-029 Main and skid registers SHALL each be an instance of sub-module pipe_data_reg (WIDTH-parametrised register with load enable and synchronous clear, sync active-high rst).

Verification
REQ-030 rst then in_valid=1, in_data=0x11, out_ready=1 -> next cycle out_valid=1, out_data=0x11, occupancy=1.
REQ-031 Stream 0x01..0x08 back-to-back, out_ready=1 -> outputs 0x01..0x08 on consecutive cycles, in_ready never 0.
REQ-032 BUSY holding 0x20, out_ready=0, offer 0x21 -> FULL, in_ready=0, out_data=0x20; raise out_ready -> 0x20 then 0x21.
REQ-033 FULL, assert flush with in_valid=1, in_data=0x33 -> next cycle EMPTY, occupancy=0, out_data=0, 0x33 never emitted.
REQ-034 With PIPE_SKID_STATS_EN, CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=0xF; flush leaves 0xF; rst -> 0.
REQ-035 Randomized in_valid/out_ready, 1000 entries -> scoreboard order match, occupancy never >2, in_ready=0 only in FULL.
